// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-register front end feeding the PWM block's five 8-bit registers.
// Define SPI_READBACK_EN to drive the addressed register on cipo during read frames.
module spi_reg_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned CNT_SAT = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_d, ncs_d;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise_c, ncs_rise_c, ncs_fall_c;
  logic                   shift_evt_c, frame_ok_c, wr_en_c;

  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [FRAME_W-1:0] shreg, shreg_nxt;
  logic [ADDR_W-1:0]  wr_addr_c;
  logic [DATA_W-1:0]  wr_data_c;

  // Input synchronizers plus one delay flop for edge detection; reset to idle bus levels
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      ncs_d     <= ncs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign copi_s      = copi_sync[SYNC_STAGES-1];
  assign ncs_s       = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise_c = sclk_s & ~sclk_d;
  assign ncs_rise_c  = ncs_s & ~ncs_d;
  assign ncs_fall_c  = ~ncs_s & ncs_d;

  // ncs edges take priority; sclk only counts while the frame is selected
  assign shift_evt_c = (state == SHIFT) & sclk_rise_c & ~ncs_s & ~ncs_fall_c & ~ncs_rise_c;

  assign wr_addr_c  = shreg[FRAME_W-2:DATA_W];
  assign wr_data_c  = shreg[DATA_W-1:0];
  assign frame_ok_c = (bit_cnt == CNT_W'(FRAME_W)) & shreg[FRAME_W-1]
                      & (wr_addr_c <= ADDR_W'(MAX_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    wr_en_c     = 1'b0;
    case (state)
      IDLE: begin
        if (ncs_fall_c) begin
          bit_cnt_nxt = '0;
          shreg_nxt   = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (ncs_rise_c) begin
          state_nxt = COMMIT;
        end else if (ncs_fall_c) begin
          // Re-selection without a deselect restarts the frame
          bit_cnt_nxt = '0;
          shreg_nxt   = '0;
        end else if (shift_evt_c) begin
          shreg_nxt = {shreg[FRAME_W-2:0], copi_s};
          if (bit_cnt != CNT_W'(CNT_SAT)) begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        wr_en_c   = frame_ok_c;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register file seen by the PWM block
  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else if (wr_en_c) begin
      case (wr_addr_c)
        ADDR_W'(0): en_reg_out_7_0  <= wr_data_c;
        ADDR_W'(1): en_reg_out_15_8 <= wr_data_c;
        ADDR_W'(2): en_reg_pwm_7_0  <= wr_data_c;
        ADDR_W'(3): en_reg_pwm_15_8 <= wr_data_c;
        ADDR_W'(4): pwm_duty_cycle  <= wr_data_c;
        default: ;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic              sclk_fall_c, tx_active;
  logic [DATA_W-1:0] hdr_c, rd_data_c, tx_reg;

  assign sclk_fall_c = ~sclk_s & sclk_d;
  assign hdr_c       = shreg_nxt[DATA_W-1:0];

  always_comb begin
    rd_data_c = '0;
    case (hdr_c[ADDR_W-1:0])
      ADDR_W'(0): rd_data_c = en_reg_out_7_0;
      ADDR_W'(1): rd_data_c = en_reg_out_15_8;
      ADDR_W'(2): rd_data_c = en_reg_pwm_7_0;
      ADDR_W'(3): rd_data_c = en_reg_pwm_15_8;
      ADDR_W'(4): rd_data_c = pwm_duty_cycle;
      default:    rd_data_c = '0;
    endcase
  end

  // Header complete on the 8th rise: latch read data, then shift it out on falling edges
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_reg    <= '0;
      tx_active <= 1'b0;
      cipo      <= 1'b0;
    end else if (ncs_s || state != SHIFT || ncs_fall_c) begin
      tx_active <= 1'b0;
      cipo      <= 1'b0;
    end else if (shift_evt_c && bit_cnt == CNT_W'(7)) begin
      tx_active <= ~hdr_c[DATA_W-1] & (hdr_c[ADDR_W-1:0] <= ADDR_W'(MAX_ADDR));
      tx_reg    <= rd_data_c;
    end else if (sclk_fall_c) begin
      if (tx_active && bit_cnt < CNT_W'(FRAME_W)) begin
        cipo   <= tx_reg[DATA_W-1];
        tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
      end else begin
        cipo <= 1'b0;
      end
    end
  end
`else
  assign cipo = 1'b0;
`endif

endmodule
